// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, register-file write mux and
// the retirement side effects (instruction counter, WWD port, halt state).
module wb_stage #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mem_wb_write,
    input  logic                 bubble,
    input  logic [WORD_SIZE-1:0] pc_val,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic [WORD_SIZE-1:0] alu_out,
    input  logic [1:0]           reg_write_target,
    input  logic [1:0]           reg_write_src,
    input  logic                 reg_write,
    input  logic                 is_wwd,
    input  logic [WORD_SIZE-1:0] output_data,
    input  logic                 is_halted,
    input  logic                 valid,
    output logic                 rf_we,
    output logic [1:0]           rf_waddr,
    output logic [WORD_SIZE-1:0] rf_wdata,
    output logic                 wb_valid,
    output logic [CNT_WIDTH-1:0] num_inst,
    output logic [WORD_SIZE-1:0] output_port,
    output logic                 halted
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [WORD_SIZE-1:0]   pc_q, pc_d;
    logic [WORD_SIZE-1:0]   mem_q, mem_d;
    logic [WORD_SIZE-1:0]   alu_q, alu_d;
    logic [1:0]             tgt_q, tgt_d;
    logic [1:0]             src_q, src_d;
    logic                   rw_q, rw_d;
    logic                   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   num_q, num_d;
    logic [WORD_SIZE-1:0]   port_q, port_d;

    logic                   load_s;
    logic                   cap_valid_s;
    logic                   retire_s;

    // WWD operand and HLT flag act at the load edge itself, so their effect is
    // committed straight into port_q / state_q instead of being staged.
    assign load_s      = mem_wb_write & (state_q == ST_RUN);
    assign cap_valid_s = valid & ~bubble;
    assign retire_s    = load_s & cap_valid_s;

    // Next-state for the MEM/WB pipeline fields
    always_comb begin
        pc_d    = pc_q;
        mem_d   = mem_q;
        alu_d   = alu_q;
        tgt_d   = tgt_q;
        src_d   = src_q;
        rw_d    = rw_q;
        valid_d = valid_q;
        if (load_s) begin
            pc_d    = pc_val;
            mem_d   = mem_data;
            alu_d   = alu_out;
            tgt_d   = reg_write_target;
            src_d   = reg_write_src;
            rw_d    = reg_write;
            valid_d = cap_valid_s;
        end else begin
            valid_d = valid_q;
        end
    end

    // Next-state for retirement side effects and the run/halt state
    always_comb begin
        num_d   = num_q;
        port_d  = port_q;
        state_d = state_q;
        if (retire_s) begin
            num_d = num_q + CNT_ONE;
            if (is_wwd) begin
                port_d = output_data;
            end else begin
                port_d = port_q;
            end
        end else begin
            num_d = num_q;
        end
        case (state_q)
            ST_RUN: begin
                if (retire_s && is_halted) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // Pipeline register, counter, output port and state flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            pc_q    <= {WORD_SIZE{1'b0}};
            mem_q   <= {WORD_SIZE{1'b0}};
            alu_q   <= {WORD_SIZE{1'b0}};
            tgt_q   <= 2'b00;
            src_q   <= 2'b00;
            rw_q    <= 1'b0;
            valid_q <= 1'b0;
            num_q   <= {CNT_WIDTH{1'b0}};
            port_q  <= {WORD_SIZE{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mem_q   <= mem_d;
            alu_q   <= alu_d;
            tgt_q   <= tgt_d;
            src_q   <= src_d;
            rw_q    <= rw_d;
            valid_q <= valid_d;
            num_q   <= num_d;
            port_q  <= port_d;
        end
    end

    // Register-file write value selected from the held instruction
    always_comb begin
        rf_wdata = alu_q;
        case (src_q)
            2'b00:   rf_wdata = alu_q;
            2'b01:   rf_wdata = mem_q;
            2'b10:   rf_wdata = pc_q;
            2'b11:   rf_wdata = alu_q;
            default: rf_wdata = alu_q;
        endcase
    end

    assign rf_we       = rw_q & valid_q & (state_q == ST_RUN);
    assign rf_waddr    = tgt_q;
    assign wb_valid    = valid_q;
    assign num_inst    = num_q;
    assign output_port = port_q;
    assign halted      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// compared against an instruction-level model of retirement.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        mem_wb_write = 1'b0;
    logic        bubble = 1'b0;
    logic [15:0] pc_val = 16'h0000;
    logic [15:0] mem_data = 16'h0000;
    logic [15:0] alu_out = 16'h0000;
    logic [1:0]  reg_write_target = 2'b00;
    logic [1:0]  reg_write_src = 2'b00;
    logic        reg_write = 1'b0;
    logic        is_wwd = 1'b0;
    logic [15:0] output_data = 16'h0000;
    logic        is_halted = 1'b0;
    logic        valid = 1'b0;

    logic        rf_we, rf_we4;
    logic [1:0]  rf_waddr, rf_waddr4;
    logic [15:0] rf_wdata, rf_wdata4;
    logic        wb_valid, wb_valid4;
    logic [15:0] num_inst;
    logic [3:0]  num_inst4;
    logic [15:0] output_port, output_port4;
    logic        halted, halted4;

    int total = 0;
    int bad = 0;

    // Model: the last instruction accepted into write-back plus architectural state
    logic        m_valid, m_rw, m_halted;
    logic [1:0]  m_src, m_tgt;
    logic [15:0] m_pc, m_mem, m_alu, m_out;
    int          m_cnt;

    always #5 clk = ~clk;

    wb_stage #(.WORD_SIZE(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .mem_wb_write(mem_wb_write), .bubble(bubble),
        .pc_val(pc_val), .mem_data(mem_data), .alu_out(alu_out),
        .reg_write_target(reg_write_target), .reg_write_src(reg_write_src),
        .reg_write(reg_write), .is_wwd(is_wwd), .output_data(output_data),
        .is_halted(is_halted), .valid(valid),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_valid(wb_valid),
        .num_inst(num_inst), .output_port(output_port), .halted(halted)
    );

    wb_stage #(.WORD_SIZE(16), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .mem_wb_write(mem_wb_write), .bubble(bubble),
        .pc_val(pc_val), .mem_data(mem_data), .alu_out(alu_out),
        .reg_write_target(reg_write_target), .reg_write_src(reg_write_src),
        .reg_write(reg_write), .is_wwd(is_wwd), .output_data(output_data),
        .is_halted(is_halted), .valid(valid),
        .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4), .wb_valid(wb_valid4),
        .num_inst(num_inst4), .output_port(output_port4), .halted(halted4)
    );

    task automatic model_reset();
        m_valid = 1'b0; m_rw = 1'b0; m_halted = 1'b0;
        m_src = 2'b00; m_tgt = 2'b00;
        m_pc = 16'h0000; m_mem = 16'h0000; m_alu = 16'h0000; m_out = 16'h0000;
        m_cnt = 0;
    endtask

    task automatic model_edge();
        if (!m_halted && mem_wb_write) begin
            m_pc = pc_val; m_mem = mem_data; m_alu = alu_out;
            m_tgt = reg_write_target; m_src = reg_write_src; m_rw = reg_write;
            m_valid = valid & ~bubble;
            if (m_valid) begin
                m_cnt = (m_cnt + 1) % 65536;
                if (is_wwd) m_out = output_data;
                if (is_halted) m_halted = 1'b1;
            end
        end
    endtask

    function automatic logic [15:0] m_wdata();
        if (m_src == 2'b01) return m_mem;
        else if (m_src == 2'b10) return m_pc;
        else return m_alu;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic bub, input logic v, input logic rw,
                         input logic [1:0] src, input logic [1:0] tgt,
                         input logic [15:0] pc, input logic [15:0] md, input logic [15:0] alu,
                         input logic wwd, input logic [15:0] od, input logic hlt);
        mem_wb_write = we; bubble = bub; valid = v; reg_write = rw;
        reg_write_src = src; reg_write_target = tgt;
        pc_val = pc; mem_data = md; alu_out = alu;
        is_wwd = wwd; output_data = od; is_halted = hlt;
        step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0);
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        total += 7;
        if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
        if (rf_waddr !== 2'b00) begin bad++; $display("FAIL reset_rf_waddr got=%h exp=0", rf_waddr); end
        if (rf_wdata !== 16'h0000) begin bad++; $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); end
        if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        if (num_inst !== 16'h0000) begin bad++; $display("FAIL reset_num_inst got=%h exp=0", num_inst); end
        if (output_port !== 16'h0000) begin bad++; $display("FAIL reset_output_port got=%h exp=0", output_port); end
        if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_alu_op();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 16'h0009, 16'h5555, 16'h1234, 1'b0, 16'h0, 1'b0);
        total += 4;
        if (rf_we !== 1'b1) begin bad++; $display("FAIL alu_rf_we got=%b exp=1", rf_we); end
        if (rf_waddr !== 2'b10) begin bad++; $display("FAIL alu_rf_waddr got=%h exp=2", rf_waddr); end
        if (rf_wdata !== 16'h1234) begin bad++; $display("FAIL alu_rf_wdata got=%h exp=1234", rf_wdata); end
        if (num_inst !== 16'h0001) begin bad++; $display("FAIL alu_num_inst got=%h exp=1", num_inst); end
    endtask

    task automatic test_src_mux();
        logic [15:0] exp_w [3];
        exp_w[0] = 16'hBEEF; exp_w[1] = 16'h0042; exp_w[2] = 16'h0007;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 2'(i + 1), 2'b01, 16'h0042, 16'hBEEF, 16'h0007,
                  1'b0, 16'h0, 1'b0);
            total++;
            if (rf_wdata !== exp_w[i]) begin
                bad++; $display("FAIL src_mux_%0d got=%h exp=%h", i + 1, rf_wdata, exp_w[i]);
            end
        end
        total++;
        if (num_inst !== 16'd3) begin bad++; $display("FAIL src_mux_count got=%0d exp=3", num_inst); end
    endtask

    task automatic test_stall_bubble();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 1'b1, 16'h00AA, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 16'h0, 16'h0, 16'($urandom),
                  1'b1, 16'($urandom), 1'b0);
            total += 2;
            if (output_port !== 16'h00AA) begin bad++; $display("FAIL stall_port got=%h exp=00aa", output_port); end
            if (num_inst !== 16'd1) begin bad++; $display("FAIL stall_count got=%0d exp=1", num_inst); end
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b11, 16'h0, 16'h0, 16'h1111, 1'b1, 16'h00BB, 1'b0);
        total += 4;
        if (wb_valid !== 1'b0) begin bad++; $display("FAIL bubble_wb_valid got=%b exp=0", wb_valid); end
        if (rf_we !== 1'b0) begin bad++; $display("FAIL bubble_rf_we got=%b exp=0", rf_we); end
        if (num_inst !== 16'd1) begin bad++; $display("FAIL bubble_count got=%0d exp=1", num_inst); end
        if (output_port !== 16'h00AA) begin bad++; $display("FAIL bubble_port got=%h exp=00aa", output_port); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 16'h0, 16'h0, 16'(i), 1'b0, 16'h0, 1'b0);
            if (i == 15) begin
                total++;
                if (num_inst4 !== 4'hF) begin bad++; $display("FAIL wrap_15 got=%h exp=f", num_inst4); end
            end
        end
        total += 2;
        if (num_inst4 !== 4'h1) begin bad++; $display("FAIL wrap_17 got=%h exp=1", num_inst4); end
        if (num_inst !== 16'd17) begin bad++; $display("FAIL wrap_wide got=%0d exp=17", num_inst); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(3, 0) != 0, $urandom_range(4, 0) == 0, $urandom_range(4, 0) != 0,
                  1'($urandom), 2'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 1'($urandom), 16'($urandom), $urandom_range(60, 0) == 0);
            total += 8;
            if (rf_we !== (m_rw & m_valid & ~m_halted)) begin bad++; $display("FAIL rnd_rf_we cyc=%0d got=%b exp=%b", i, rf_we, m_rw & m_valid & ~m_halted); end
            if (rf_waddr !== m_tgt) begin bad++; $display("FAIL rnd_rf_waddr cyc=%0d got=%h exp=%h", i, rf_waddr, m_tgt); end
            if (rf_wdata !== m_wdata()) begin bad++; $display("FAIL rnd_rf_wdata cyc=%0d got=%h exp=%h", i, rf_wdata, m_wdata()); end
            if (wb_valid !== m_valid) begin bad++; $display("FAIL rnd_wb_valid cyc=%0d got=%b exp=%b", i, wb_valid, m_valid); end
            if (num_inst !== 16'(m_cnt)) begin bad++; $display("FAIL rnd_num_inst cyc=%0d got=%0d exp=%0d", i, num_inst, m_cnt); end
            if (num_inst4 !== 4'(m_cnt % 16)) begin bad++; $display("FAIL rnd_num_inst4 cyc=%0d got=%0d exp=%0d", i, num_inst4, m_cnt % 16); end
            if (output_port !== m_out) begin bad++; $display("FAIL rnd_port cyc=%0d got=%h exp=%h", i, output_port, m_out); end
            if (halted !== m_halted) begin bad++; $display("FAIL rnd_halted cyc=%0d got=%b exp=%b", i, halted, m_halted); end
        end
    endtask

    task automatic test_halt();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
        total += 2;
        if (halted !== 1'b0) begin bad++; $display("FAIL halt_ignored got=%b exp=0", halted); end
        if (num_inst !== 16'd0) begin bad++; $display("FAIL halt_ignored_count got=%0d exp=0", num_inst); end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1);
        total += 2;
        if (halted !== 1'b1) begin bad++; $display("FAIL halt_set got=%b exp=1", halted); end
        if (num_inst !== 16'd1) begin bad++; $display("FAIL halt_count got=%0d exp=1", num_inst); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 16'h0, 16'h0, 16'($urandom),
                  1'b1, 16'h1234, 1'b0);
            total += 4;
            if (rf_we !== 1'b0) begin bad++; $display("FAIL halt_rf_we got=%b exp=0", rf_we); end
            if (rf_waddr !== 2'b01) begin bad++; $display("FAIL halt_frozen got=%h exp=1", rf_waddr); end
            if (num_inst !== 16'd1) begin bad++; $display("FAIL halt_frozen_count got=%0d exp=1", num_inst); end
            if (output_port !== 16'h0000) begin bad++; $display("FAIL halt_port got=%h exp=0", output_port); end
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (halted !== 1'b0) begin bad++; $display("FAIL halt_reset got=%b exp=0", halted); end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 16'h0, 16'h0, 16'hCAFE, 1'b0, 16'h0, 1'b0);
        total++;
        if (rf_we !== 1'b1) begin bad++; $display("FAIL async_pre_rf_we got=%b exp=1", rf_we); end
        #1 reset_n = 1'b0;
        #1;
        total += 3;
        if (rf_we !== 1'b0) begin bad++; $display("FAIL async_rf_we got=%b exp=0", rf_we); end
        if (wb_valid !== 1'b0) begin bad++; $display("FAIL async_wb_valid got=%b exp=0", wb_valid); end
        if (num_inst !== 16'd0) begin bad++; $display("FAIL async_num_inst got=%0d exp=0", num_inst); end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 16'h0, 16'h7777, 16'h0, 1'b0, 16'h0, 1'b0);
        total += 2;
        if (rf_wdata !== 16'h7777) begin bad++; $display("FAIL async_after_wdata got=%h exp=7777", rf_wdata); end
        if (num_inst !== 16'd1) begin bad++; $display("FAIL async_after_count got=%0d exp=1", num_inst); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu_op();
        test_src_mux();
        test_stall_bubble();
        test_counter_wrap();
        test_random();
        test_halt();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
